// File: rtl/cplx_accum.sv
// Complex accumulate-and-dump stage: sums len packed {re,im} products in
// guard-bit accumulators and emits one saturated 32-bit complex result.
module cplx_accum #(
    parameter int ACC_W = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] out_real,
    output logic [31:0] out_im,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DUMP
    } state_t;

    state_t                  r_state;
    logic [8:0]              r_len;
    logic [8:0]              r_cnt;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic                    r_busy;
    logic                    r_out_valid;
    logic [31:0]             r_out_re;
    logic [31:0]             r_out_im;
    logic                    r_overflow;

    logic signed [ACC_W-1:0] w_add_re;
    logic signed [ACC_W-1:0] w_add_im;
    logic [8:0]              w_len_ext;
    logic                    w_last;
    logic                    w_re_pos;
    logic                    w_re_neg;
    logic                    w_im_pos;
    logic                    w_im_neg;
    logic [31:0]             w_sat_re;
    logic [31:0]             w_sat_im;

    assign w_add_re  = {{(ACC_W-32){in_data[63]}}, in_data[63:32]};
    assign w_add_im  = {{(ACC_W-32){in_data[31]}}, in_data[31:0]};
    assign w_len_ext = (len == 8'd0) ? 9'd256 : {1'b0, len};
    assign w_last    = (r_cnt == (r_len - 9'd1));

    // Out of 32-bit range when the bits above bit 31 are not all copies of the sign.
    assign w_re_pos = !r_acc_re[ACC_W-1] && (|r_acc_re[ACC_W-2:31]);
    assign w_re_neg =  r_acc_re[ACC_W-1] && !(&r_acc_re[ACC_W-2:31]);
    assign w_im_pos = !r_acc_im[ACC_W-1] && (|r_acc_im[ACC_W-2:31]);
    assign w_im_neg =  r_acc_im[ACC_W-1] && !(&r_acc_im[ACC_W-2:31]);

    assign w_sat_re = w_re_pos ? 32'h7FFF_FFFF :
                      w_re_neg ? 32'h8000_0000 : r_acc_re[31:0];
    assign w_sat_im = w_im_pos ? 32'h7FFF_FFFF :
                      w_im_neg ? 32'h8000_0000 : r_acc_im[31:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= 9'd0;
            r_cnt       <= 9'd0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= 32'd0;
            r_out_im    <= 32'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_len    <= w_len_ext;
                        r_cnt    <= 9'd0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_acc_re <= r_acc_re + w_add_re;
                        r_acc_im <= r_acc_im + w_add_im;
                        r_cnt    <= r_cnt + 9'd1;
                        if (w_last) begin
                            r_state <= S_DUMP;
                        end
                    end
                end
                S_DUMP: begin
                    // busy stays up through the out_valid cycle
                    r_out_re    <= w_sat_re;
                    r_out_im    <= w_sat_im;
                    r_overflow  <= w_re_pos | w_re_neg | w_im_pos | w_im_neg;
                    r_out_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_real  = r_out_re;
    assign out_im    = r_out_im;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cplx_accum.sv
// Directed bench for cplx_accum: table of short blocks plus hand-written
// sequences for gaps, len=0, mid-block reset and ignored controls.
module tb_cplx_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [63:0] in_data;
    logic        busy;
    logic        out_valid;
    logic [31:0] out_real;
    logic [31:0] out_im;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    cplx_accum #(.ACC_W(40)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_real  (out_real),
        .out_im    (out_im),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (out_valid === 1'b1) pulses <= pulses + 1;
    end

    typedef struct {
        logic [7:0]       len;
        int               n;
        logic [3:0][31:0] re;
        logic [3:0][31:0] im;
        logic [31:0]      exp_re;
        logic [31:0]      exp_im;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'hAA;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im);
        in_valid = 1'b1;
        in_data  = {re, im};
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Called right after the edge that accepted the last sample.
    task automatic wait_dump(input string nm, input logic [31:0] er,
                             input logic [31:0] ei, input logic eo);
        int p0;
        p0 = pulses;
        chk({nm, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_busy_in_valid"}, {31'd0, busy}, 32'd1);
        chk({nm, "_re"}, out_real, er);
        chk({nm, "_im"}, out_im, ei);
        chk({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        tick();
        chk({nm, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
        chk({nm, "_hold_re"}, out_real, er);
        chk({nm, "_one_pulse"}, pulses - p0, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b0;
        in_data  = '0;

        vecs[0] = '{8'd4, 4, {32'd1, 32'd1, 32'd1, 32'd1},
                    {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    32'h00000004, 32'hFFFFFFFC, 1'b0};
        vecs[1] = '{8'd2, 2, {32'd0, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF},
                    {32'd0, 32'd0, 32'h80000000, 32'h80000000},
                    32'h7FFFFFFF, 32'h80000000, 1'b1};
        vecs[2] = '{8'd1, 1, {32'd0, 32'd0, 32'd0, 32'd5},
                    {32'd0, 32'd0, 32'd0, 32'd5},
                    32'd5, 32'd5, 1'b0};
        vecs[3] = '{8'd2, 2, {32'd0, 32'd0, 32'd2, 32'd1},
                    {32'd0, 32'd0, 32'd2, 32'd1},
                    32'd3, 32'd3, 1'b0};
        vecs[4] = '{8'd2, 2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'h80000000},
                    {32'd0, 32'd0, 32'd1, 32'd0},
                    32'h80000000, 32'd1, 1'b1};
        vecs[5] = '{8'd2, 2, {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF},
                    {32'd0, 32'd0, 32'd0, 32'h80000000},
                    32'h7FFFFFFF, 32'h80000000, 1'b0};

        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_re", out_real, 32'd0);
        chk("rst_im", out_im, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // in_valid in IDLE must not leak into the next block
        send(32'd9, 32'd9);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_start(vecs[v].len);
            for (int k = 0; k < vecs[v].n; k++)
                send(vecs[v].re[k], vecs[v].im[k]);
            wait_dump($sformatf("vec%0d", v), vecs[v].exp_re,
                      vecs[v].exp_im, vecs[v].exp_ovf);
        end

        // gapped input
        do_start(8'd3);
        send(32'd10, 32'd20);
        tick(); tick();
        send(32'hFFFFFFFD, 32'd5);
        tick(); tick();
        chk("gap_busy", {31'd0, busy}, 32'd1);
        chk("gap_no_valid", {31'd0, out_valid}, 32'd0);
        send(32'd100, 32'hFFFFFFCE);
        wait_dump("gap", 32'd107, 32'hFFFFFFE7, 1'b0);

        // len=0 means 256
        do_start(8'd0);
        for (int k = 0; k < 255; k++) send(32'd1, 32'h7FFFFFFF);
        chk("len0_busy_255", {31'd0, busy}, 32'd1);
        chk("len0_no_valid_255", {31'd0, out_valid}, 32'd0);
        send(32'd1, 32'h7FFFFFFF);
        wait_dump("len0", 32'd256, 32'h7FFFFFFF, 1'b1);

        // reset mid-block
        begin
            int p0;
            p0 = pulses;
            do_start(8'd4);
            send(32'd3, 32'd3);
            send(32'd3, 32'd3);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("mrst_busy", {31'd0, busy}, 32'd0);
            chk("mrst_valid", {31'd0, out_valid}, 32'd0);
            chk("mrst_re", out_real, 32'd0);
            chk("mrst_im", out_im, 32'd0);
            chk("mrst_ovf", {31'd0, overflow}, 32'd0);
            tick(); tick(); tick();
            chk("mrst_no_pulse", pulses - p0, 32'd0);
            chk("mrst_idle", {31'd0, busy}, 32'd0);
        end
        do_start(8'd1);
        send(32'd5, 32'hFFFFFFF9);
        wait_dump("post_rst", 32'd5, 32'hFFFFFFF9, 1'b0);

        // start in ACCUM and in_valid in DUMP are ignored
        do_start(8'd2);
        send(32'd1, 32'd1);
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        send(32'd2, 32'd2);
        in_valid = 1'b1;
        in_data  = {32'd100, 32'd100};
        wait_dump("ign", 32'd3, 32'd3, 1'b0);
        in_valid = 1'b0;
        in_data  = '0;
        do_start(8'd1);
        send(32'd7, 32'd8);
        wait_dump("after_ign", 32'd7, 32'd8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
